dino_sprite_engine: RTL and testbench
=====================================

// Module: dino_sprite_engine
// PURPOSE
//  Parametrised dinosaur player block: a per-frame state machine (idle/run/jump/duck)
//  with a full symmetric parabolic jump arc, a two-frame running-leg animation and a
//  ducking pose. It also renders the player sprite as a 1-bit pixel stream from the VGA
//  scan address. Sits beside the obstacle and score renderers; px is OR-ed into the video
//  mux, and height/airborne feed collision logic.
// PARAMETERS
//  SPR_W      82   sprite width, pixels
//  SPR_H      88   standing/jump sprite height, pixels
//  DUCK_H     52   ducking sprite height, pixels (bottom-aligned to ground)
//  X0         80   left column of sprite
//  GROUND     402  row just below sprite feet
//  JUMP_T     30   frames from take-off to apex; full arc = 2*JUMP_T frames
//  HDIV_SH    2    height = (t*(2*JUMP_T - t)) >> HDIV_SH
//  ANIM_DIV   6    frames per leg-animation phase while running
// PORTS
//  CLK          in   1   pixel clock; all logic on posedge
//  RESET        in   1   asynchronous, active-low reset
//  fresh        in   1   frame signal, CLK domain; a 1->0 edge marks one frame tick
//  game_status  in   1   1 = game running, 0 = paused/over
//  button_jump  in   1   level, sampled at frame tick
//  button_duck  in   1   level, sampled at frame tick
//  row_addr     in   9   scan row
//  col_addr     in   10  scan column
//  px           out  1   sprite pixel, 2-cycle latency from row/col
//  height       out  9   current jump height above ground, pixels
//  airborne     out  1   1 while state == JUMP
//  ducking      out  1   1 while state == DUCK
// BEHAVIOUR
//  - Frame tick: tick = fresh_q & ~fresh (one registered delay); every state update
//    happens only on a tick cycle. No update occurs while game_status == 0 (all state is
//    frozen, including mid-jump t).
//  - Reset (RESET low, any time): state = IDLE, t = 0, anim_cnt = 0, leg = 0, px = 0,
//    height = 0, airborne = 0, ducking = 0. Pipeline regs are cleared.
//  - States: IDLE, RUN, JUMP, DUCK.
//    IDLE: enter RUN on a tick with game_status = 1.
//    RUN:  on a tick, button_jump -> JUMP with t = 1; else button_duck -> DUCK.
//          Jump wins over duck when both are sampled on the same tick.
//    JUMP: on each tick t <= t+1; when t == 2*JUMP_T, next tick -> RUN with t = 0.
//          Duck is ignored in the air. A held jump does not re-trigger until RUN is
//          re-entered, and it then takes off on the next tick.
//    DUCK: on a tick, if !button_duck -> RUN; if button_jump -> JUMP (t = 1).
//  - height = (t*(2*JUMP_T - t)) >> HDIV_SH, using a 16-bit unsigned intermediate.
//    Registered, updated the cycle after t changes. height = 0 outside JUMP. Default
//    apex = 225 at t = 30, returning to 0 at t = 60.
//  - Leg animation: in RUN and DUCK, anim_cnt counts ticks 0..ANIM_DIV-1, and leg
//    toggles at wrap. In IDLE and JUMP, leg = 0 and anim_cnt holds.
//  - Frame select: IDLE/JUMP -> STAND; RUN -> RUN_A/RUN_B by leg;
//    DUCK -> DUCK_A/DUCK_B by leg.
//  - Render stage 1 (registered):
//    - top = GROUND - height - h, with h = DUCK_H in DUCK, else SPR_H.
//    - hit = row_addr >= top && row_addr < GROUND - height
//            && col_addr >= X0 && col_addr < X0 + SPR_W.
//    - ROM address = {frame, row_addr - top, SPR_W-1-(col_addr-X0)}, computed in
//      11-bit signed arithmetic; the address is don't-care when hit = 0.
//  - Render stage 2: px <= hit_q & rom_bit. There is no wrap at screen edges: height is
//    bounded so that top >= 0 for legal parameters (GROUND - SPR_H >= apex).
// STRUCTURE
//  - Shared package dino_pkg: state enum (IDLE, RUN, JUMP, DUCK); frame enum (STAND,
//    RUN_A, RUN_B, DUCK_A, DUCK_B); constants SCREEN_W = 640 and SCREEN_H = 480.
//  - Sub-module dino_sprite_rom: synchronous-read, 1-bit-wide ROM of 5 frames x SPR_H
//    rows x SPR_W columns. Contents come from an init file. Duck frames use only rows
//    0..DUCK_H-1.
// TESTING
//  1. RESET low mid-jump (t = 17) -> all outputs 0 next cycle; state = IDLE; px = 0 for
//     the whole next frame.
//  2. game_status = 1, jump pressed on one tick -> airborne for 60 ticks;
//     height = 0, 14, ..., 225 at t = 30, ..., 0. Back in RUN at tick 61.
//  3. Jump and duck asserted on the same tick in RUN -> JUMP, ducking stays 0; duck
//     held through landing -> DUCK one tick after RUN.
//  4. game_status dropped at t = 20 for 10 ticks -> height holds at 200; resumes at
//     t = 21 when game_status returns to 1.
//  5. RUN for 24 ticks -> leg toggles at ticks 6, 12, 18, 24; frame alternates
//     RUN_A/RUN_B.
//  6. Scan a full frame at height 0 -> px = 1 only inside rows 314..401 and cols 80..161,
//     matches ROM STAND with 2-cycle latency; in DUCK, rows 350..401 only.

Source files
------------

// File: rtl/dino_sprite_engine_pkg.sv
// Shared types and helpers for the dinosaur player block: player states, sprite
// frame ids, screen geometry and the sprite image generator.
package dino_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_JUMP, ST_DUCK} state_e;
  typedef enum logic [2:0] {FR_STAND, FR_RUN_A, FR_RUN_B, FR_DUCK_A, FR_DUCK_B} frame_e;

  localparam int SCREEN_W   = 640;
  localparam int SCREEN_H   = 480;
  localparam int NUM_FRAMES = 5;

  // Sprite image source: one bit per (frame, row, column). Swapping art means
  // swapping this function for a table generated from the artwork file.
  function automatic logic sprite_bit(input int fr, input int r, input int c);
    return ((r + 2 * c + 3 * fr) % 5) < 2;
  endfunction

endpackage

// File: rtl/dino_sprite_rom.sv
// Synchronous-read 1-bit sprite ROM: NUM_FRAMES x SPR_H x SPR_W, registered output.
module dino_sprite_rom
  import dino_pkg::*;
#(
  parameter int SPR_W = 82,
  parameter int SPR_H = 88,
  parameter int RW    = $clog2(SPR_H),
  parameter int CW    = $clog2(SPR_W)
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic [2:0]    frame_i,
  input  logic [RW-1:0] row_i,
  input  logic [CW-1:0] col_i,
  output logic          bit_o
);

  logic bit_d, bit_q;

  // Addresses outside the stored image read as transparent.
  always_comb begin
    bit_d = 1'b0;
    if (int'(frame_i) < NUM_FRAMES && int'(row_i) < SPR_H && int'(col_i) < SPR_W)
      bit_d = sprite_bit(int'(frame_i), int'(row_i), int'(col_i));
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) bit_q <= 1'b0;
    else        bit_q <= bit_d;
  end

  assign bit_o = bit_q;

endmodule

// File: rtl/dino_sprite_engine.sv
// Dinosaur player: per-frame idle/run/jump/duck FSM with parabolic jump arc and
// leg animation, plus a 2-cycle-latency 1-bit sprite renderer driven by scan address.
module dino_sprite_engine
  import dino_pkg::*;
#(
  parameter int SPR_W    = 82,
  parameter int SPR_H    = 88,
  parameter int DUCK_H   = 52,
  parameter int X0       = 80,
  parameter int GROUND   = 402,
  parameter int JUMP_T   = 30,
  parameter int HDIV_SH  = 2,
  parameter int ANIM_DIV = 6
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       fresh,
  input  logic       game_status,
  input  logic       button_jump,
  input  logic       button_duck,
  input  logic [8:0] row_addr,
  input  logic [9:0] col_addr,
  output logic       px,
  output logic [8:0] height,
  output logic       airborne,
  output logic       ducking
);

  localparam int TW = $clog2(2 * JUMP_T + 1);
  localparam int AW = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam int RW = $clog2(SPR_H);
  localparam int CW = $clog2(SPR_W);

  localparam logic [TW-1:0]     T_END     = TW'(2 * JUMP_T);
  localparam logic [AW-1:0]     ANIM_LAST = AW'(ANIM_DIV - 1);
  localparam logic [15:0]       SPAN      = 16'(2 * JUMP_T);
  localparam logic signed [10:0] GROUND_S = 11'(GROUND);
  localparam logic signed [10:0] SPR_H_S  = 11'(SPR_H);
  localparam logic signed [10:0] DUCK_H_S = 11'(DUCK_H);
  localparam logic signed [10:0] X0_S     = 11'(X0);
  localparam logic signed [10:0] XE_S     = 11'(X0 + SPR_W);
  localparam logic signed [10:0] XR_S     = 11'(X0 + SPR_W - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] t_q, t_d;
  logic [AW-1:0] anim_q, anim_d;
  logic          leg_q, leg_d;
  logic          fresh_q;
  logic          tick;
  logic [8:0]    height_q, height_d;
  logic [15:0]   t_ext, prod;

  // Frame tick is the falling edge of fresh, seen one cycle late.
  assign tick = fresh_q & ~fresh;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      fresh_q  <= 1'b0;
      state_q  <= ST_IDLE;
      t_q      <= '0;
      anim_q   <= '0;
      leg_q    <= 1'b0;
      height_q <= '0;
    end else begin
      fresh_q  <= fresh;
      state_q  <= state_d;
      t_q      <= t_d;
      anim_q   <= anim_d;
      leg_q    <= leg_d;
      height_q <= height_d;
    end
  end

  // Everything is frozen unless a tick arrives while the game is running.
  always_comb begin
    state_d = state_q;
    t_d     = t_q;
    anim_d  = anim_q;
    leg_d   = leg_q;
    if (tick && game_status) begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN: begin
          if (button_jump) begin
            state_d = ST_JUMP;
            t_d     = TW'(1);
          end else if (button_duck) begin
            state_d = ST_DUCK;
          end
        end
        ST_JUMP: begin
          if (t_q == T_END) begin
            state_d = ST_RUN;
            t_d     = '0;
          end else begin
            t_d = t_q + TW'(1);
          end
        end
        ST_DUCK: begin
          if (button_jump) begin
            state_d = ST_JUMP;
            t_d     = TW'(1);
          end else if (!button_duck) begin
            state_d = ST_RUN;
          end
        end
        default: state_d = ST_IDLE;
      endcase

      if (state_q == ST_RUN || state_q == ST_DUCK) begin
        if (anim_q == ANIM_LAST) begin
          anim_d = '0;
          leg_d  = ~leg_q;
        end else begin
          anim_d = anim_q + AW'(1);
        end
      end else begin
        leg_d = 1'b0;
      end
    end
  end

  // Parabolic arc, evaluated one cycle behind t.
  always_comb begin
    t_ext    = 16'(t_q);
    prod     = t_ext * (SPAN - t_ext);
    height_d = (state_q == ST_JUMP) ? 9'(prod >> HDIV_SH) : '0;
  end

  // Render stage 1: hit test and ROM address; the ROM read is the stage register.
  logic signed [10:0] bot_s, top_s, row_s, col_s;
  logic               hit_d, hit_q;
  logic [RW-1:0]      rom_row;
  logic [CW-1:0]      rom_col;
  frame_e             frame_sel;
  logic               rom_bit;
  logic               px_q;

  always_comb begin
    bot_s   = GROUND_S - $signed({2'b00, height_q});
    top_s   = bot_s - ((state_q == ST_DUCK) ? DUCK_H_S : SPR_H_S);
    row_s   = $signed({2'b00, row_addr});
    col_s   = $signed({1'b0, col_addr});
    hit_d   = (row_s >= top_s) && (row_s < bot_s) && (col_s >= X0_S) && (col_s < XE_S);
    rom_row = RW'(row_s - top_s);
    rom_col = CW'(XR_S - col_s);
  end

  always_comb begin
    frame_sel = FR_STAND;
    case (state_q)
      ST_RUN:  frame_sel = leg_q ? FR_RUN_B : FR_RUN_A;
      ST_DUCK: frame_sel = leg_q ? FR_DUCK_B : FR_DUCK_A;
      default: frame_sel = FR_STAND;
    endcase
  end

  dino_sprite_rom #(
    .SPR_W(SPR_W),
    .SPR_H(SPR_H),
    .RW   (RW),
    .CW   (CW)
  ) u_rom (
    .CLK    (CLK),
    .RESET  (RESET),
    .frame_i(frame_sel),
    .row_i  (rom_row),
    .col_i  (rom_col),
    .bit_o  (rom_bit)
  );

  // Render stage 2.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      hit_q <= 1'b0;
      px_q  <= 1'b0;
    end else begin
      hit_q <= hit_d;
      px_q  <= hit_q & rom_bit;
    end
  end

  assign px       = px_q;
  assign height   = height_q;
  assign airborne = (state_q == ST_JUMP);
  assign ducking  = (state_q == ST_DUCK);

endmodule

// File: tb/tb_dino_sprite_engine.sv
// Randomized bench for dino_sprite_engine against a behavioural player/sprite model.
module tb_dino_sprite_engine;

  localparam int SPR_W = 82, SPR_H = 88, DUCK_H = 52, X0 = 80, GROUND = 402;
  localparam int JUMP_T = 30, HDIV_SH = 2, ANIM_DIV = 6;

  logic       CLK = 1'b0;
  logic       RESET = 1'b1;
  logic       fresh = 1'b0, game_status = 1'b0, button_jump = 1'b0, button_duck = 1'b0;
  logic [8:0] row_addr = '0;
  logic [9:0] col_addr = '0;
  logic       px, airborne, ducking;
  logic [8:0] height;

  int n_chk = 0, n_fail = 0;
  int chk_on = 0, scan_on = 0, rst_hold = 0;
  int win_top = 314, out_cnt = 0, rs_ones = 0, ab;

  always #5 CLK = ~CLK;

  dino_sprite_engine #(
    .SPR_W(SPR_W), .SPR_H(SPR_H), .DUCK_H(DUCK_H), .X0(X0), .GROUND(GROUND),
    .JUMP_T(JUMP_T), .HDIV_SH(HDIV_SH), .ANIM_DIV(ANIM_DIV)
  ) dut (
    .CLK(CLK), .RESET(RESET), .fresh(fresh), .game_status(game_status),
    .button_jump(button_jump), .button_duck(button_duck),
    .row_addr(row_addr), .col_addr(col_addr),
    .px(px), .height(height), .airborne(airborne), .ducking(ducking)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model. States: 0 idle, 1 run, 2 jump, 3 duck.
  function automatic int pat(input int f, input int r, input int c);
    return (((r + 2 * c + 3 * f) % 5) < 2) ? 1 : 0;
  endfunction

  int m_state, m_t, m_anim, m_leg, m_height, m_fq, m_hit1, m_bit1, m_px;
  int r1, r2, c1, c2;

  always @(posedge CLK or negedge RESET) begin
    int tick, top, bot, fr, hit, row, col, old;
    if (!RESET) begin
      m_state = 0; m_t = 0; m_anim = 0; m_leg = 0; m_height = 0; m_fq = 0;
      m_hit1 = 0; m_bit1 = 0; m_px = 0; r1 = 0; r2 = 0; c1 = 0; c2 = 0;
    end else begin
      row = int'(row_addr);
      col = int'(col_addr);
      m_px = m_hit1 & m_bit1;
      bot = GROUND - m_height;
      top = bot - ((m_state == 3) ? DUCK_H : SPR_H);
      hit = (row >= top && row < bot && col >= X0 && col < X0 + SPR_W) ? 1 : 0;
      fr = (m_state == 1) ? 1 + m_leg : (m_state == 3) ? 3 + m_leg : 0;
      m_bit1 = hit ? pat(fr, row - top, X0 + SPR_W - 1 - col) : 0;
      m_hit1 = hit;
      m_height = (m_state == 2) ? ((m_t * (2 * JUMP_T - m_t)) >> HDIV_SH) : 0;
      tick = (m_fq == 1 && fresh == 1'b0) ? 1 : 0;
      m_fq = fresh ? 1 : 0;
      if (tick == 1 && game_status) begin
        old = m_state;
        case (old)
          0: m_state = 1;
          1: if (button_jump) begin m_state = 2; m_t = 1; end
             else if (button_duck) m_state = 3;
          2: if (m_t == 2 * JUMP_T) begin m_state = 1; m_t = 0; end
             else m_t = m_t + 1;
          default: if (button_jump) begin m_state = 2; m_t = 1; end
                   else if (!button_duck) m_state = 1;
        endcase
        if (old == 1 || old == 3) begin
          if (m_anim == ANIM_DIV - 1) begin m_anim = 0; m_leg = 1 - m_leg; end
          else m_anim = m_anim + 1;
        end else m_leg = 0;
      end
      r2 = r1; r1 = row; c2 = c1; c1 = col;
    end
  end

  always @(negedge CLK) begin
    if (chk_on == 1) begin
      chk("px", 32'(px), 32'(m_px));
      chk("height", 32'(height), 32'(m_height));
      chk("airborne", 32'(airborne), 32'(m_state == 2));
      chk("ducking", 32'(ducking), 32'(m_state == 3));
      if (scan_on == 1 && px === 1'b1 &&
          !(r2 >= win_top && r2 <= GROUND - 1 && c2 >= X0 && c2 <= X0 + SPR_W - 1))
        out_cnt++;
      if (rst_hold == 1 && px !== 1'b0) rs_ones++;
    end
  end

  task automatic rstep();
    @(posedge CLK);
    #1;
    row_addr = 9'($urandom_range(420, 80));
    col_addr = 10'($urandom_range(190, 60));
  endtask

  task automatic frame();
    fresh = 1'b1;
    repeat (8) rstep();
    fresh = 1'b0;
    repeat (8) rstep();
  endtask

  task automatic scan();
    out_cnt = 0;
    scan_on = 1;
    for (int r = 300; r <= 410; r++)
      for (int c = 70; c <= 170; c++) begin
        @(posedge CLK);
        #1;
        row_addr = 9'(r);
        col_addr = 10'(c);
      end
    repeat (3) begin @(posedge CLK); #1; end
    scan_on = 0;
  endtask

  initial begin
    #2 RESET = 1'b0;
    repeat (3) rstep();
    chk_on = 1;
    chk("rst_px", 32'(px), 0);
    chk("rst_height", 32'(height), 0);
    chk("rst_airborne", 32'(airborne), 0);
    chk("rst_ducking", 32'(ducking), 0);
    RESET = 1'b1;
    rstep();

    // Full jump arc.
    game_status = 1'b1;
    frame();
    button_jump = 1'b1;
    frame();
    button_jump = 1'b0;
    chk("arc_air_t1", 32'(airborne), 1);
    chk("arc_h_t1", 32'(height), 14);
    ab = 1;
    for (int k = 2; k <= 60; k++) begin
      frame();
      if (airborne) ab++;
      if (k == 30) chk("arc_apex", 32'(height), 225);
      if (k == 60) chk("arc_h_t60", 32'(height), 0);
    end
    frame();
    chk("arc_landed", 32'(airborne), 0);
    chk("arc_air_ticks", 32'(ab), 60);

    // Jump beats duck; held duck takes over one tick after landing.
    button_jump = 1'b1; button_duck = 1'b1;
    frame();
    button_jump = 1'b0;
    chk("jd_air", 32'(airborne), 1);
    chk("jd_duck", 32'(ducking), 0);
    repeat (59) frame();
    chk("jd_air_t60", 32'(airborne), 1);
    frame();
    chk("jd_run_duck", 32'(ducking), 0);
    chk("jd_run_air", 32'(airborne), 0);
    frame();
    chk("jd_ducked", 32'(ducking), 1);
    button_duck = 1'b0;
    frame();
    chk("jd_unduck", 32'(ducking), 0);

    // Pause mid-jump.
    button_jump = 1'b1;
    frame();
    button_jump = 1'b0;
    repeat (19) frame();
    chk("pause_h20", 32'(height), 200);
    game_status = 1'b0;
    repeat (10) frame();
    chk("pause_hold", 32'(height), 200);
    chk("pause_air", 32'(airborne), 1);
    game_status = 1'b1;
    frame();
    chk("pause_h21", 32'(height), 204);
    repeat (45) frame();
    chk("pause_landed", 32'(airborne), 0);

    // Reset mid-jump at t = 17.
    button_jump = 1'b1;
    frame();
    button_jump = 1'b0;
    repeat (16) frame();
    chk("mid_h17", 32'(height), (17 * 43) >> 2);
    RESET = 1'b0;
    rst_hold = 1;
    rs_ones = 0;
    rstep();
    chk("mid_rst_air", 32'(airborne), 0);
    chk("mid_rst_height", 32'(height), 0);
    repeat (16) rstep();
    rst_hold = 0;
    chk("mid_rst_px_ones", 32'(rs_ones), 0);
    RESET = 1'b1;
    rstep();

    // Running leg animation.
    frame();
    repeat (24) frame();

    // Full-sprite scans: standing at ground, then ducking.
    RESET = 1'b0;
    rstep();
    RESET = 1'b1;
    win_top = GROUND - SPR_H;
    scan();
    chk("stand_out_window", 32'(out_cnt), 0);
    frame();
    button_duck = 1'b1;
    frame();
    chk("scan_ducking", 32'(ducking), 1);
    win_top = GROUND - DUCK_H;
    scan();
    chk("duck_out_window", 32'(out_cnt), 0);
    button_duck = 1'b0;

    // Random play.
    repeat (150) begin
      button_jump = ($urandom_range(3) == 0);
      button_duck = ($urandom_range(2) == 0);
      game_status = ($urandom_range(7) != 0);
      frame();
    end

    chk_on = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
